// File: rtl/zilla_pkg.sv
// Shared encodings for the iterative divider: operation codes and FSM states.
package zilla_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/zilla_iter_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow short-circuited straight to DONE.
module zilla_iter_div
  import zilla_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5
) (
  input  logic                      div_clk,
  input  logic                      div_rst,
  input  logic                      wdt_reset_i,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [XLEN-1:0]           dividend_i,
  input  logic [XLEN-1:0]           divisor_i,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_i,
  output logic                      div_busy_o,
  output logic                      rem_busy_o,
  output logic                      div_valid_o,
  output logic                      rem_valid_o,
  output logic [XLEN-1:0]           result_o,
  output logic [GPR_ADDR_WIDTH-1:0] rd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  op_e                        op_reg, op_next;
  logic [GPR_ADDR_WIDTH-1:0]  tag_reg, tag_next;
  logic [XLEN-1:0]            divisor_reg, divisor_next;
  logic [XLEN-1:0]            quot_reg, quot_next;
  logic [XLEN:0]              rem_reg, rem_next;
  logic                       neg_q_reg, neg_q_next;
  logic                       neg_r_reg, neg_r_next;
  logic [XLEN-1:0]            result_reg, result_next;
  logic [GPR_ADDR_WIDTH-1:0]  rd_out_reg, rd_out_next;

  op_e             op_in;
  logic            dividend_neg, divisor_neg;
  logic            div_zero, overflow;
  logic [XLEN-1:0] dividend_mag, divisor_mag;
  logic [XLEN+1:0] shifted, trial;
  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quot;

  assign op_in        = op_e'(op_i);
  assign dividend_neg = op_is_signed(op_in) && dividend_i[XLEN-1];
  assign divisor_neg  = op_is_signed(op_in) && divisor_i[XLEN-1];
  assign dividend_mag = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_mag  = divisor_neg ? -divisor_i : divisor_i;
  assign div_zero     = (divisor_i == '0);
  assign overflow     = op_is_signed(op_in) && (dividend_i == MOST_NEG) && (divisor_i == '1);

  // Shift the next dividend bit into the partial remainder and try the subtraction;
  // a borrow out of the top bit means the trial failed and the remainder is restored.
  assign shifted   = {rem_reg, quot_reg[XLEN-1]};
  assign trial     = shifted - {2'b00, divisor_reg};
  assign step_rem  = trial[XLEN+1] ? shifted[XLEN:0] : trial[XLEN:0];
  assign step_quot = {quot_reg[XLEN-2:0], ~trial[XLEN+1]};

  always_ff @(posedge div_clk or negedge div_rst) begin
    if (!div_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    tag_next     = tag_reg;
    divisor_next = divisor_reg;
    quot_next    = quot_reg;
    rem_next     = rem_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    result_next  = result_reg;
    rd_out_next  = rd_out_reg;
    if (wdt_reset_i) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            op_next  = op_in;
            tag_next = rd_i;
            if (div_zero) begin
              result_next = op_is_rem(op_in) ? dividend_i : '1;
              rd_out_next = rd_i;
              state_next  = ST_DONE;
            end else if (overflow) begin
              result_next = op_is_rem(op_in) ? '0 : dividend_i;
              rd_out_next = rd_i;
              state_next  = ST_DONE;
            end else begin
              divisor_next = divisor_mag;
              quot_next    = dividend_mag;
              rem_next     = '0;
              neg_q_next   = dividend_neg ^ divisor_neg;
              neg_r_next   = dividend_neg;
              cnt_next     = CNT_W'(XLEN);
              state_next   = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          quot_next = step_quot;
          rem_next  = step_rem;
          cnt_next  = cnt_reg - CNT_W'(1);
          // The result register loads on the edge into DONE so it is valid alongside the strobe.
          if (cnt_reg == CNT_W'(1)) begin
            if (op_is_rem(op_reg)) begin
              result_next = neg_r_reg ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
            end else begin
              result_next = neg_q_reg ? -step_quot : step_quot;
            end
            rd_out_next = tag_reg;
            state_next  = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge div_clk or negedge div_rst) begin
    if (!div_rst) begin
      cnt_reg     <= '0;
      op_reg      <= OP_DIV;
      tag_reg     <= '0;
      divisor_reg <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      rd_out_reg  <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      tag_reg     <= tag_next;
      divisor_reg <= divisor_next;
      quot_reg    <= quot_next;
      rem_reg     <= rem_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      result_reg  <= result_next;
      rd_out_reg  <= rd_out_next;
    end
  end

  assign div_busy_o  = (state_reg == ST_CALC) && !op_is_rem(op_reg);
  assign rem_busy_o  = (state_reg == ST_CALC) && op_is_rem(op_reg);
  assign div_valid_o = (state_reg == ST_DONE) && !op_is_rem(op_reg);
  assign rem_valid_o = (state_reg == ST_DONE) && op_is_rem(op_reg);
  assign result_o    = result_reg;
  assign rd_o        = rd_out_reg;

endmodule

// File: tb/tb_zilla_iter_div.sv
// Scoreboard bench for zilla_iter_div: stimulus pushes expected results, a
// negedge monitor pops and checks every valid strobe including its cycle.
module tb_zilla_iter_div;
  import zilla_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            div_clk = 1'b0;
  logic            div_rst = 1'b0;
  logic            wdt_reset_i = 1'b0;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = 2'b00;
  logic [XLEN-1:0] dividend_i = '0;
  logic [XLEN-1:0] divisor_i = '0;
  logic [RW-1:0]   rd_i = '0;
  logic            div_busy_o, rem_busy_o, div_valid_o, rem_valid_o;
  logic [XLEN-1:0] result_o;
  logic [RW-1:0]   rd_o;

  zilla_iter_div #(.XLEN(XLEN), .GPR_ADDR_WIDTH(RW)) dut (
    .div_clk     (div_clk),
    .div_rst     (div_rst),
    .wdt_reset_i (wdt_reset_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_i        (rd_i),
    .div_busy_o  (div_busy_o),
    .rem_busy_o  (rem_busy_o),
    .div_valid_o (div_valid_o),
    .rem_valid_o (rem_valid_o),
    .result_o    (result_o),
    .rd_o        (rd_o)
  );

  always #5 div_clk = ~div_clk;

  // cyc names the period following each rising edge; a start sampled at an
  // edge gives t = cyc of that period.
  int cyc = 0;
  always @(posedge div_clk) cyc <= cyc + 1;

  typedef struct {
    logic            rem;
    logic [XLEN-1:0] res;
    logic [RW-1:0]   rd;
    int              at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge div_clk) begin : monitor
    exp_t e;
    if (div_rst && (div_valid_o || rem_valid_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {62'd0, div_valid_o, rem_valid_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe", {62'd0, div_valid_o, rem_valid_o}, e.rem ? 64'd1 : 64'd2);
        check("result", 64'(result_o), 64'(e.res));
        check("rd", 64'(rd_o), 64'(e.rd));
        check("latency", 64'(cyc), 64'(e.at));
        $display("txn rd=%0d result=%08h cyc=%0d", rd_o, result_o, cyc);
      end
    end
  end

  // lat < 0 means no result is expected from this request.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RW-1:0] rd, input logic [XLEN-1:0] res, input int lat,
                       input logic wdt, output int t);
    @(negedge div_clk);
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    rd_i        = rd;
    wdt_reset_i = wdt;
    t = cyc + 1;
    if (lat >= 0) exp_q.push_back('{op[1], res, rd, t + lat});
    @(negedge div_clk);
    start_i     = 1'b0;
    wdt_reset_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge div_clk);
      n++;
    end
    check("completion_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge div_clk);
  endtask

  task automatic run(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [RW-1:0] rd, input logic [XLEN-1:0] res, input int lat);
    int t;
    issue(op, a, b, rd, res, lat, 1'b0, t);
    wait_done(XLEN + 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge div_clk);
    check("reset_outputs", {23'd0, div_busy_o, rem_busy_o, div_valid_o, rem_valid_o, rd_o, result_o}, 64'd0);
    div_rst = 1'b1;
    @(negedge div_clk);

    // DIVU 100/7 with busy profile over the whole operation
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, XLEN, 1'b0, t);
    check("rem_busy_on_div", 64'(rem_busy_o), 64'd0);
    for (int k = 0; k <= XLEN; k++) begin
      check("div_busy_profile", 64'(div_busy_o), (k < XLEN) ? 64'd1 : 64'd0);
      if (k < XLEN) @(negedge div_clk);
    end
    wait_done(XLEN + 8);

    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, XLEN, 1'b0, t);
    check("rem_busy", 64'(rem_busy_o), 64'd1);
    check("div_busy_on_rem", 64'(div_busy_o), 64'd0);
    wait_done(XLEN + 8);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, XLEN);

    // divide by zero and signed overflow finish without entering CALC
    issue(OP_DIV, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 0, 1'b0, t);
    check("div0_busy", {62'd0, div_busy_o, rem_busy_o}, 64'd0);
    wait_done(8);
    run(OP_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 0, 1'b0, t);
    check("ovf_busy", {62'd0, div_busy_o, rem_busy_o}, 64'd0);
    wait_done(8);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 0);

    // unsigned and sign-correction corners through the iterative path
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, XLEN);
    run(OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd11, 32'd5, XLEN);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 5'd12, 32'h1999_9999, XLEN);
    run(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd13, 32'hFFFF_FFF2, XLEN);
    run(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd14, 32'd2, XLEN);
    run(OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFFE, XLEN);
    run(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd16, 32'd14, XLEN);
    run(OP_DIVU, 32'd7, 32'd7, 5'd17, 32'd1, XLEN);
    run(OP_DIV, 32'h8000_0000, 32'd1, 5'd18, 32'h8000_0000, XLEN);

    // a second start during CALC must be ignored
    issue(OP_DIVU, 32'd50, 32'd5, 5'd7, 32'd10, XLEN, 1'b0, t);
    while (cyc < t + 4) @(negedge div_clk);
    start_i    = 1'b1;
    op_i       = OP_DIVU;
    dividend_i = 32'd9;
    divisor_i  = 32'd3;
    rd_i       = 5'd12;
    @(negedge div_clk);
    start_i = 1'b0;
    wait_done(XLEN + 8);
    repeat (3) @(negedge div_clk);
    check("result_hold", 64'(result_o), 64'd10);
    check("rd_hold", 64'(rd_o), 64'd7);

    // watchdog abort mid-CALC: no strobe, previous result kept
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, -1, 1'b0, t);
    while (cyc < t + 9) @(negedge div_clk);
    check("busy_before_wdt", 64'(div_busy_o), 64'd1);
    wdt_reset_i = 1'b1;
    @(negedge div_clk);
    wdt_reset_i = 1'b0;
    check("busy_after_wdt", 64'(div_busy_o), 64'd0);
    repeat (XLEN + 8) @(negedge div_clk);
    check("wdt_result_kept", 64'(result_o), 64'd10);
    check("wdt_rd_kept", 64'(rd_o), 64'd7);

    // start coinciding with watchdog reset is dropped
    issue(OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd0, -1, 1'b1, t);
    check("wdt_start_busy", {62'd0, div_busy_o, rem_busy_o}, 64'd0);
    repeat (XLEN + 8) @(negedge div_clk);
    check("wdt_start_result", 64'(result_o), 64'd10);

    run(OP_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, XLEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
